fifo_write_pointer_handler: RTL and testbench
=============================================

// Module: fifo_write_pointer_handler
// PURPOSE
//  Source-domain write-side pointer logic of the async FIFO. It sits directly upstream of
//  bus_synchronizer: gray_write_pointer feeds the synchronizer's asynchronous_data input.
//  It also consumes the read pointer that a bus_synchronizer has already brought into this domain.
//  From these it generates the RAM write address/strobe, registered full/almost_full and fill level.
// PARAMETERS
//  ADDR_WIDTH             3  FIFO address bits; DEPTH = 2**ADDR_WIDTH; pointer width P = ADDR_WIDTH+1 (>=2)
//  ALMOST_FULL_THRESHOLD  6  almost_full asserted when fill level >= this value (1..DEPTH)
// PORTS
//  clk                      in   1           write-domain clock; all state updates on rising edge
//  reset                    in   1           synchronous, active-low reset
//  write_enable             in   1           write request from producer
//  synchronous_read_pointer in   P           gray read pointer, already synchronized to clk
//  write_accepted           out  1           write_enable & ~full (combinational RAM write strobe)
//  write_address            out  ADDR_WIDTH  binary write address = write binary pointer[ADDR_WIDTH-1:0]
//  gray_write_pointer       out  P           registered gray pointer, to bus_synchronizer
//  fill_level               out  P           registered occupancy estimate, 0..DEPTH
//  full                     out  1           registered
//  almost_full              out  1           registered
// BEHAVIOUR
//  - Reset (reset==0 at a rising edge): binary pointer, gray_write_pointer, fill_level, full and
//    almost_full all go to 0. Reset overrides write_enable, including mid-operation and when full.
//  - Accept: write_accepted = write_enable & ~full. At that edge bin_next = bin + 1 (mod 2**P).
//    Otherwise bin_next = bin. write_address shows the slot being written in the current cycle.
//  - gray_write_pointer <= bin_next ^ (bin_next >> 1). It is registered only, never driven from
//    combinational logic. Between consecutive edges it changes in at most one bit; this is
//    mandatory for safe synchronization.
//  - Wrap-around: after 2**P accepted writes the pointer returns to 0. No special case is needed.
//  - Read pointer: rbin = gray-to-binary(synchronous_read_pointer), taken combinationally from the
//    current input value.
//  - fill_level <= (bin_next - rbin) mod 2**P.
//  - full <= (gray_next == {~rgray[P-1:P-2], rgray[P-3:0]}), which is equivalent to fill_level_next == DEPTH.
//  - almost_full <= (fill_level_next >= ALMOST_FULL_THRESHOLD).
//  - Status is pessimistic. full/fill_level fall only after the synchronized read pointer advances,
//    which is >= STAGE_COUNT cycles late. They never under-report occupancy, so overflow is impossible.
//  - Simultaneous events: a write on the same edge as a read-pointer change uses both new values.
//    For example, write at fill 7 plus read pointer advance -> fill stays 7 and full stays 0.
//  - Latency: accepted write -> gray_write_pointer/full/fill_level update at that same edge,
//    i.e. visible 1 cycle after the request is sampled.
//  - A write_enable while full is dropped: no pointer change, write_accepted = 0.
// STRUCTURE
//  - Shared package/header fifo_pkg: FIFO_ADDR_WIDTH, ptr width macro, bin2gray function.
//    bus_synchronizer parameters are derived from the same macro.
//  - One sub-module: gray_to_binary #(WIDTH) (XOR prefix chain). The read-side handler reuses it.
//  - Remaining logic is a single sequential process plus next-state combinational logic. No FSM
//    beyond the pointer/status registers.
// TESTING (ADDR_WIDTH=3, P=4, threshold 6; pointer widths match the 4-bit gray_codes.txt)
//  1 Reset: hold reset=0 one cycle with write_enable=1 -> all outputs 0, gray_write_pointer=0000.
//  2 Fill: 8 writes with read ptr 0000 -> gray 0001,0011,0010,0110,0111,0101,0100,1100;
//    write_address 0..7; almost_full rises after write 6; full=1 and fill_level=8 after write 8.
//  3 Overflow: write_enable=1 for 3 cycles while full -> write_accepted=0, gray holds 1100, fill 8.
//  4 Drain: drive read ptr 0001 -> next edge full=0, fill_level=7, almost_full=1.
//    Then read ptr 0110 -> fill_level=4, almost_full=0.
//  5 Wrap: 32 writes with read ptr tracking (one behind) -> pointer wraps 1000->0000 twice.
//    Every gray step has Hamming distance exactly 1, compared against gray_codes.txt.
//  6 Reset mid-run: assert reset with gray=0110 and write_enable=1 -> next edge all outputs 0.
//    Next write gives gray 0001.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry, pointer-width macro and binary-to-gray helper.
// The bus_synchronizer and both pointer handlers derive their widths from the same macro.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

`define FIFO_PTR_W(aw) ((aw) + 1)

package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH            = 3;
  localparam int FIFO_PTR_WIDTH             = `FIFO_PTR_W(FIFO_ADDR_WIDTH);
  localparam int FIFO_ALMOST_FULL_THRESHOLD = 6;

  // Callers zero-extend into the 32-bit argument and truncate the result to pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

`endif

// File: rtl/gray_to_binary.sv
// Combinational gray-to-binary conversion; each binary bit is the XOR of all gray bits at or above it.
// Shared by the write-side and read-side pointer handlers.
module gray_to_binary #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign o_bin[gi] = ^i_gray[WIDTH-1:gi];
    end
  endgenerate

endmodule

// File: rtl/fifo_write_pointer_handler.sv
// Write-domain pointer logic of the async FIFO: RAM write strobe/address, registered gray pointer
// for the bus_synchronizer, and pessimistic registered full / almost_full / fill level.
module fifo_write_pointer_handler
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH            = FIFO_ADDR_WIDTH,
  parameter int ALMOST_FULL_THRESHOLD = FIFO_ALMOST_FULL_THRESHOLD,
  localparam int P                    = `FIFO_PTR_W(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [P-1:0]          synchronous_read_pointer,
  output logic                  write_accepted,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [P-1:0]          gray_write_pointer,
  output logic [P-1:0]          fill_level,
  output logic                  full,
  output logic                  almost_full
);

  localparam logic [P-1:0] AF_THRESHOLD = P'(ALMOST_FULL_THRESHOLD);

  logic [P-1:0] r_bin;
  logic [P-1:0] r_gray;
  logic [P-1:0] r_fill;
  logic         r_full;
  logic         r_almost_full;

  logic [P-1:0] w_bin_next;
  logic [P-1:0] w_gray_next;
  logic [P-1:0] w_read_bin;
  logic [P-1:0] w_fill_next;
  logic [P-1:0] w_full_gray;

  gray_to_binary #(
    .WIDTH (P)
  ) u_read_g2b (
    .i_gray (synchronous_read_pointer),
    .o_bin  (w_read_bin)
  );

  assign write_accepted = write_enable & ~r_full;
  assign write_address  = r_bin[ADDR_WIDTH-1:0];

  assign w_bin_next  = r_bin + {{(P-1){1'b0}}, write_accepted};
  assign w_gray_next = P'(bin2gray(32'(w_bin_next)));
  assign w_fill_next = w_bin_next - w_read_bin;

  // Full when the write pointer is exactly one lap ahead: top two gray bits inverted, rest equal.
  generate
    if (P == 2) begin : g_full_narrow
      assign w_full_gray = ~synchronous_read_pointer;
    end else begin : g_full_wide
      assign w_full_gray = {~synchronous_read_pointer[P-1:P-2], synchronous_read_pointer[P-3:0]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bin         <= '0;
      r_gray        <= '0;
      r_fill        <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
    end else begin
      r_bin         <= w_bin_next;
      r_gray        <= w_gray_next;
      r_fill        <= w_fill_next;
      r_full        <= (w_gray_next == w_full_gray);
      r_almost_full <= (w_fill_next >= AF_THRESHOLD);
    end
  end

  assign gray_write_pointer = r_gray;
  assign fill_level         = r_fill;
  assign full               = r_full;
  assign almost_full        = r_almost_full;

endmodule

// File: tb/tb_fifo_write_pointer_handler.sv
// Self-checking bench for fifo_write_pointer_handler (ADDR_WIDTH=3, threshold 6), using a
// write/read counting model and a gray-code lookup table.
module tb_fifo_write_pointer_handler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       write_enable = 1'b0;
  logic [3:0] synchronous_read_pointer = 4'h0;
  logic       write_accepted;
  logic [2:0] write_address;
  logic [3:0] gray_write_pointer;
  logic [3:0] fill_level;
  logic       full;
  logic       almost_full;

  always #5 clk = ~clk;

  fifo_write_pointer_handler #(
    .ADDR_WIDTH            (3),
    .ALMOST_FULL_THRESHOLD (6)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .write_enable             (write_enable),
    .synchronous_read_pointer (synchronous_read_pointer),
    .write_accepted           (write_accepted),
    .write_address            (write_address),
    .gray_write_pointer       (gray_write_pointer),
    .fill_level               (fill_level),
    .full                     (full),
    .almost_full              (almost_full)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // 4-bit gray code sequence, index = binary count.
  logic [3:0] gray_codes [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  // Model: total accepted writes and reads seen by the write side; status derived from the difference.
  int         m_wr = 0;
  int         m_rd = 0;
  int         m_fill = 0;
  bit         m_full = 1'b0;
  bit         m_af = 1'b0;
  logic [3:0] exp_gray = 4'h0;
  bit         exp_acc;
  logic [2:0] exp_addr;
  logic       obs_acc;
  logic [2:0] obs_addr;

  // One clock: drive inputs after the falling edge, sample combinational outputs, take the
  // rising edge, advance the model, return 1 time unit after the edge.
  task automatic edge_cycle(input bit we, input int rd, input bit rst);
    @(negedge clk);
    write_enable             = we;
    reset                    = ~rst;
    synchronous_read_pointer = gray_codes[rd % 16];
    exp_acc  = we && !m_full;
    exp_addr = 3'(m_wr % 8);
    #1;
    obs_acc  = write_accepted;
    obs_addr = write_address;
    @(posedge clk);
    if (rst) begin
      m_wr   = 0;
      m_rd   = 0;
      m_fill = 0;
    end else begin
      if (exp_acc) m_wr++;
      m_rd   = rd;
      m_fill = m_wr - m_rd;
    end
    m_full   = (m_fill == 8);
    m_af     = (m_fill >= 6);
    exp_gray = gray_codes[m_wr % 16];
    #1;
  endtask

  task automatic test_reset();
    edge_cycle(1'b1, 0, 1'b1);
    n_checks++; if (gray_write_pointer !== 4'b0000) $display("FAIL reset_gray got %b want 0000", gray_write_pointer); else n_pass++;
    n_checks++; if (fill_level !== 4'd0) $display("FAIL reset_fill got %0d want 0", fill_level); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else n_pass++;
    n_checks++; if (almost_full !== 1'b0) $display("FAIL reset_af got %b want 0", almost_full); else n_pass++;
    $display("reset: gray=%b fill=%0d full=%b af=%b", gray_write_pointer, fill_level, full, almost_full);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      edge_cycle(1'b1, 0, 1'b0);
      n_checks++; if (obs_acc !== 1'b1) $display("FAIL fill_acc[%0d] got %b want 1", i, obs_acc); else n_pass++;
      n_checks++; if (obs_addr !== 3'(i)) $display("FAIL fill_addr[%0d] got %0d want %0d", i, obs_addr, i); else n_pass++;
      n_checks++; if (gray_write_pointer !== exp_gray) $display("FAIL fill_gray[%0d] got %b want %b", i, gray_write_pointer, exp_gray); else n_pass++;
      n_checks++; if (fill_level !== 4'(m_fill)) $display("FAIL fill_level[%0d] got %0d want %0d", i, fill_level, m_fill); else n_pass++;
      n_checks++; if (almost_full !== m_af) $display("FAIL fill_af[%0d] got %b want %b", i, almost_full, m_af); else n_pass++;
      n_checks++; if (full !== m_full) $display("FAIL fill_full[%0d] got %b want %b", i, full, m_full); else n_pass++;
      $display("fill write %0d: addr=%0d gray=%b fill=%0d af=%b full=%b", i, obs_addr, gray_write_pointer, fill_level, almost_full, full);
    end
    n_checks++; if (gray_write_pointer !== 4'b1100) $display("FAIL fill_final_gray got %b want 1100", gray_write_pointer); else n_pass++;
    n_checks++; if (full !== 1'b1 || fill_level !== 4'd8) $display("FAIL fill_final got full=%b fill=%0d want full=1 fill=8", full, fill_level); else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      edge_cycle(1'b1, 0, 1'b0);
      n_checks++; if (obs_acc !== 1'b0) $display("FAIL ovf_acc[%0d] got %b want 0", i, obs_acc); else n_pass++;
      n_checks++; if (gray_write_pointer !== 4'b1100) $display("FAIL ovf_gray[%0d] got %b want 1100", i, gray_write_pointer); else n_pass++;
      n_checks++; if (fill_level !== 4'd8 || full !== 1'b1) $display("FAIL ovf_status[%0d] got fill=%0d full=%b want fill=8 full=1", i, fill_level, full); else n_pass++;
      $display("overflow attempt %0d: acc=%b gray=%b fill=%0d", i, obs_acc, gray_write_pointer, fill_level);
    end
  endtask

  task automatic test_drain();
    edge_cycle(1'b0, 1, 1'b0);
    n_checks++; if (full !== 1'b0) $display("FAIL drain1_full got %b want 0", full); else n_pass++;
    n_checks++; if (fill_level !== 4'd7) $display("FAIL drain1_fill got %0d want 7", fill_level); else n_pass++;
    n_checks++; if (almost_full !== 1'b1) $display("FAIL drain1_af got %b want 1", almost_full); else n_pass++;
    $display("drain rptr=0001: fill=%0d full=%b af=%b", fill_level, full, almost_full);
    edge_cycle(1'b0, 4, 1'b0);
    n_checks++; if (fill_level !== 4'd4) $display("FAIL drain2_fill got %0d want 4", fill_level); else n_pass++;
    n_checks++; if (almost_full !== 1'b0) $display("FAIL drain2_af got %b want 0", almost_full); else n_pass++;
    $display("drain rptr=0110: fill=%0d full=%b af=%b", fill_level, full, almost_full);
  endtask

  task automatic test_wrap();
    logic [3:0] prev;
    int         wraps = 0;
    for (int i = 0; i < 32; i++) begin
      prev = gray_write_pointer;
      edge_cycle(1'b1, m_wr - 1, 1'b0);
      if (prev == 4'b1000 && gray_write_pointer == 4'b0000) wraps++;
      n_checks++; if (gray_write_pointer !== exp_gray) $display("FAIL wrap_gray[%0d] got %b want %b", i, gray_write_pointer, exp_gray); else n_pass++;
      n_checks++; if ($countones(gray_write_pointer ^ prev) != 1) $display("FAIL wrap_hamming[%0d] got %b->%b want distance 1", i, prev, gray_write_pointer); else n_pass++;
      n_checks++; if (fill_level !== 4'(m_fill)) $display("FAIL wrap_fill[%0d] got %0d want %0d", i, fill_level, m_fill); else n_pass++;
      $display("wrap write %0d: gray %b->%b fill=%0d", i, prev, gray_write_pointer, fill_level);
    end
    n_checks++; if (wraps != 2) $display("FAIL wrap_count got %0d want 2", wraps); else n_pass++;
  endtask

  task automatic test_simultaneous();
    while (m_fill < 7) edge_cycle(1'b1, m_rd, 1'b0);
    n_checks++; if (fill_level !== 4'd7) $display("FAIL simul_pre_fill got %0d want 7", fill_level); else n_pass++;
    edge_cycle(1'b1, m_rd + 1, 1'b0);
    n_checks++; if (obs_acc !== 1'b1) $display("FAIL simul_acc got %b want 1", obs_acc); else n_pass++;
    n_checks++; if (fill_level !== 4'd7) $display("FAIL simul_fill got %0d want 7", fill_level); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL simul_full got %b want 0", full); else n_pass++;
    n_checks++; if (gray_write_pointer !== exp_gray) $display("FAIL simul_gray got %b want %b", gray_write_pointer, exp_gray); else n_pass++;
    $display("simultaneous write+read at fill 7: fill=%0d full=%b", fill_level, full);
  endtask

  task automatic test_reset_mid();
    edge_cycle(1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) edge_cycle(1'b1, 0, 1'b0);
    n_checks++; if (gray_write_pointer !== 4'b0110) $display("FAIL rmid_pre_gray got %b want 0110", gray_write_pointer); else n_pass++;
    edge_cycle(1'b1, 0, 1'b1);
    n_checks++; if (gray_write_pointer !== 4'b0000) $display("FAIL rmid_gray got %b want 0000", gray_write_pointer); else n_pass++;
    n_checks++; if (fill_level !== 4'd0 || full !== 1'b0 || almost_full !== 1'b0) $display("FAIL rmid_status got fill=%0d full=%b af=%b want 0/0/0", fill_level, full, almost_full); else n_pass++;
    $display("reset mid-run: gray=%b fill=%0d", gray_write_pointer, fill_level);
    edge_cycle(1'b1, 0, 1'b0);
    n_checks++; if (obs_addr !== 3'd0) $display("FAIL rmid_addr got %0d want 0", obs_addr); else n_pass++;
    n_checks++; if (gray_write_pointer !== 4'b0001) $display("FAIL rmid_next_gray got %b want 0001", gray_write_pointer); else n_pass++;
    n_checks++; if (fill_level !== 4'd1) $display("FAIL rmid_next_fill got %0d want 1", fill_level); else n_pass++;
    $display("first write after reset: gray=%b fill=%0d", gray_write_pointer, fill_level);
  endtask

  task automatic test_random();
    logic [3:0] prev;
    bit         we;
    int         rd;
    for (int i = 0; i < 300; i++) begin
      prev = gray_write_pointer;
      we   = ($urandom_range(0, 3) != 0);
      rd   = m_rd;
      if (m_rd < m_wr && $urandom_range(0, 2) == 0) rd = m_rd + 1;
      edge_cycle(we, rd, 1'b0);
      n_checks++; if (obs_acc !== exp_acc || obs_addr !== exp_addr) $display("FAIL rand_strobe[%0d] got acc=%b addr=%0d want acc=%b addr=%0d", i, obs_acc, obs_addr, exp_acc, exp_addr); else n_pass++;
      n_checks++; if (gray_write_pointer !== exp_gray) $display("FAIL rand_gray[%0d] got %b want %b", i, gray_write_pointer, exp_gray); else n_pass++;
      n_checks++; if ($countones(gray_write_pointer ^ prev) > 1) $display("FAIL rand_hamming[%0d] got %b->%b want distance <=1", i, prev, gray_write_pointer); else n_pass++;
      n_checks++; if (fill_level !== 4'(m_fill) || full !== m_full || almost_full !== m_af) $display("FAIL rand_status[%0d] got fill=%0d full=%b af=%b want fill=%0d full=%b af=%b", i, fill_level, full, almost_full, m_fill, m_full, m_af); else n_pass++;
      $display("rand %0d: we=%b rd=%0d acc=%b gray=%b fill=%0d full=%b af=%b", i, we, rd, obs_acc, gray_write_pointer, fill_level, full, almost_full);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
